// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets and claim-id definitions for the interrupt aggregation controller.
package irq_ctrl_pkg;

    localparam int ID_W = 5;
    localparam logic [ID_W-1:0] ID_NONE = '0;

    localparam logic [7:0] IRQ_PENDING  = 8'h00;
    localparam logic [7:0] IRQ_ENABLE   = 8'h04;
    localparam logic [7:0] IRQ_EDGE     = 8'h08;
    localparam logic [7:0] IRQ_CLAIM    = 8'h0C;
    localparam logic [7:0] IRQ_INSERV   = 8'h10;
    localparam logic [7:0] IRQ_COMPLETE = 8'h14;

    // Ids are 1-based on the bus; index 0 maps to id 1.
    function automatic logic id_match(input logic [ID_W-1:0] id, input int idx);
        return id == ID_W'(idx + 1);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source multi-flop synchronizer with a one-cycle history flop for rising-edge detection.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = s_o & ~s_d_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt aggregation controller: synchronizes raw lines, tracks pending/in-service state,
// masks with ENABLE and raises one registered request; software uses CLAIM/COMPLETE over rib.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [N_SRC-1:0] irq_src_i,
    output logic             irq_o
);

    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] edge_mode_q, edge_mode_d;
    logic [N_SRC-1:0] inserv_q, inserv_d;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] claim_hit;
    logic [N_SRC-1:0] complete_hit;
    logic             irq_q, irq_d;
    logic [ID_W-1:0]  claim_id;
    logic [ID_W-1:0]  wr_id;
    logic [7:0]       off;
    logic             wr_pending, wr_enable, wr_edge, wr_claim, wr_complete;
    logic             unused_bits;

    assign off         = addr_i[7:0];
    assign wr_id       = data_i[ID_W-1:0];
    assign wr_pending  = we_i && (off == IRQ_PENDING);
    assign wr_enable   = we_i && (off == IRQ_ENABLE);
    assign wr_edge     = we_i && (off == IRQ_EDGE);
    assign wr_claim    = we_i && (off == IRQ_CLAIM);
    assign wr_complete = we_i && (off == IRQ_COMPLETE);
    assign unused_bits = ^{addr_i[31:8], data_i[31:N_SRC]};

    assign elig = pending_q & enable_q & ~inserv_q;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            irq_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .rst    (rst),
                .d_i    (irq_src_i[gi]),
                .s_o    (s[gi]),
                .rise_o (rise[gi])
            );

            // Only an eligible source can be claimed; only an in-service one completed.
            assign claim_hit[gi]    = wr_claim & id_match(wr_id, gi) & elig[gi];
            assign complete_hit[gi] = wr_complete & id_match(wr_id, gi) & inserv_q[gi];

            // Edge mode: a fresh edge beats any clear in the same cycle. Level mode tracks the line.
            assign pending_d[gi] = edge_mode_q[gi]
                                 ? (rise[gi] | (pending_q[gi] & ~((wr_pending & data_i[gi]) | claim_hit[gi])))
                                 : s[gi];
            assign inserv_d[gi]  = claim_hit[gi] | (inserv_q[gi] & ~complete_hit[gi]);
        end
    endgenerate

    assign enable_d    = wr_enable ? data_i[N_SRC-1:0] : enable_q;
    assign edge_mode_d = wr_edge   ? data_i[N_SRC-1:0] : edge_mode_q;
    assign irq_d       = |elig;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            inserv_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            inserv_q    <= inserv_d;
            irq_q       <= irq_d;
        end
    end

    assign irq_o = irq_q;

    // Lowest index wins: scan downward so the last assignment is the smallest eligible index.
    always_comb begin
        claim_id = ID_NONE;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                claim_id = ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (off)
            IRQ_PENDING: data_o[N_SRC-1:0] = pending_q;
            IRQ_ENABLE:  data_o[N_SRC-1:0] = enable_q;
            IRQ_EDGE:    data_o[N_SRC-1:0] = edge_mode_q;
            IRQ_CLAIM:   data_o[ID_W-1:0]  = claim_id;
            IRQ_INSERV:  data_o[N_SRC-1:0] = inserv_q;
            default:     data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized and directed bench for irq_ctrl, checked every cycle against a behavioural model.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int N_SRC       = 8;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             we_i = 1'b0;
    logic [31:0]      addr_i = '0;
    logic [31:0]      data_i = '0;
    logic [31:0]      data_o;
    logic [N_SRC-1:0] irq_src_i = '0;
    logic             irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .N_SRC       (N_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o)
    );

    // Behavioural model: raw samples history, register bits and the registered request.
    logic [N_SRC-1:0] m_pend = '0;
    logic [N_SRC-1:0] m_en   = '0;
    logic [N_SRC-1:0] m_mode = '0;
    logic [N_SRC-1:0] m_ins  = '0;
    logic             m_irq  = 1'b0;
    logic [N_SRC-1:0] raw_q[$];

    task automatic model_clock();
        logic [N_SRC-1:0] s, sd, elig, np, ni;
        logic [7:0] off;
        int id;
        bit claim_ok, done_ok;
        s    = raw_q[SYNC_STAGES-1];
        sd   = raw_q[SYNC_STAGES];
        elig = m_pend & m_en & ~m_ins;
        off  = addr_i[7:0];
        id   = int'(data_i[4:0]);
        claim_ok = we_i && off == IRQ_CLAIM && id >= 1 && id <= N_SRC && elig[id-1];
        done_ok  = we_i && off == IRQ_COMPLETE && id >= 1 && id <= N_SRC && m_ins[id-1];
        np = m_pend;
        ni = m_ins;
        for (int i = 0; i < N_SRC; i++) begin
            if (m_mode[i]) begin
                if (s[i] && !sd[i]) np[i] = 1'b1;
                else if ((we_i && off == IRQ_PENDING && data_i[i]) || (claim_ok && id == i + 1)) np[i] = 1'b0;
            end else begin
                np[i] = s[i];
            end
        end
        if (claim_ok) ni[id-1] = 1'b1;
        if (done_ok)  ni[id-1] = 1'b0;
        if (we_i && off == IRQ_ENABLE) m_en   = data_i[N_SRC-1:0];
        if (we_i && off == IRQ_EDGE)   m_mode = data_i[N_SRC-1:0];
        m_irq  = |elig;
        m_pend = np;
        m_ins  = ni;
        raw_q.push_front(irq_src_i);
        void'(raw_q.pop_back());
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = '0; m_en = '0; m_mode = '0; m_ins = '0; m_irq = 1'b0;
            raw_q.delete();
            for (int k = 0; k <= SYNC_STAGES; k++) raw_q.push_back('0);
        end else begin
            model_clock();
        end
    end

    function automatic logic [31:0] exp_rd(input logic [7:0] off);
        logic [N_SRC-1:0] elig;
        logic [31:0] r;
        r = '0;
        elig = m_pend & m_en & ~m_ins;
        case (off)
            IRQ_PENDING: r[N_SRC-1:0] = m_pend;
            IRQ_ENABLE:  r[N_SRC-1:0] = m_en;
            IRQ_EDGE:    r[N_SRC-1:0] = m_mode;
            IRQ_INSERV:  r[N_SRC-1:0] = m_ins;
            IRQ_CLAIM: begin
                for (int i = N_SRC - 1; i >= 0; i--) if (elig[i]) r = i + 1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("irq_o", {31'b0, irq_o}, {31'b0, m_irq});
        chk($sformatf("data_o@%02h", addr_i[7:0]), data_o, exp_rd(addr_i[7:0]));
    endtask

    task automatic tick();
        @(negedge clk);
        model_cmp();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        we_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [23:0] hi = '0);
        we_i = 1'b1; addr_i = {hi, off}; data_i = d;
        $display("wr  off=%02h data=%08h", off, d);
        tick();
        we_i = 1'b0;
    endtask

    task automatic rd_lit(input string nm, input logic [7:0] off, input logic [31:0] exp);
        we_i = 1'b0; addr_i = {24'h0, off};
        @(negedge clk);
        model_cmp();
        chk(nm, data_o, exp);
        $display("rd  %s off=%02h data=%08h", nm, off, data_o);
        @(posedge clk);
        #2;
    endtask

    task automatic irq_lit(input string nm, input logic exp);
        we_i = 1'b0;
        @(negedge clk);
        model_cmp();
        chk(nm, {31'b0, irq_o}, {31'b0, exp});
        $display("irq %s irq_o=%0b", nm, irq_o);
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0]  offs [7];
        logic [7:0]  off;
        logic [31:0] d, c;
        int k;
        offs = '{IRQ_PENDING, IRQ_ENABLE, IRQ_EDGE, IRQ_CLAIM, IRQ_INSERV, IRQ_COMPLETE, 8'h18};

        @(posedge clk); #2;
        rd_lit("rst_pending", IRQ_PENDING, 0);
        rd_lit("rst_claim", IRQ_CLAIM, 0);
        irq_lit("rst_irq", 1'b0);
        rst = 1'b1;
        idle(1);

        // Edge path: one-cycle pulse, request after SYNC_STAGES+2 edges.
        wr(IRQ_EDGE, 1);
        wr(IRQ_ENABLE, 1);
        irq_src_i[0] = 1'b1; tick(); irq_src_i[0] = 1'b0;
        irq_lit("lat_c1", 1'b0);
        irq_lit("lat_c2", 1'b0);
        irq_lit("lat_c3", 1'b0);
        irq_lit("lat_c4", 1'b1);
        rd_lit("edge_pending", IRQ_PENDING, 1);
        rd_lit("edge_claim", IRQ_CLAIM, 1);
        wr(IRQ_CLAIM, 1);
        rd_lit("claimed_pending", IRQ_PENDING, 0);
        rd_lit("claimed_inserv", IRQ_INSERV, 1);
        irq_lit("claimed_irq", 1'b0);
        wr(IRQ_COMPLETE, 1);
        rd_lit("completed_inserv", IRQ_INSERV, 0);

        // Priority with level sources 3 and 5.
        wr(IRQ_EDGE, 0);
        wr(IRQ_ENABLE, 32'hFF);
        irq_src_i = 8'h28;
        idle(4);
        rd_lit("prio_claim_a", IRQ_CLAIM, 4);
        wr(IRQ_CLAIM, 4);
        rd_lit("prio_claim_b", IRQ_CLAIM, 6);
        wr(IRQ_COMPLETE, 4);
        rd_lit("prio_claim_c", IRQ_CLAIM, 4);
        irq_src_i = '0;
        idle(5);

        // Masked pending source, then unmask.
        wr(IRQ_ENABLE, 0);
        wr(IRQ_EDGE, 4);
        irq_src_i[2] = 1'b1; tick(); irq_src_i[2] = 1'b0;
        idle(4);
        rd_lit("mask_pending", IRQ_PENDING, 4);
        irq_lit("mask_irq_off", 1'b0);
        wr(IRQ_ENABLE, 4);
        irq_lit("unmask_irq_c0", 1'b0);
        irq_lit("unmask_irq_c1", 1'b1);

        // W1C colliding with a new synchronized edge: set wins.
        wr(IRQ_PENDING, 4);
        wr(IRQ_EDGE, 5);
        irq_src_i[0] = 1'b1; tick(); tick();
        wr(IRQ_PENDING, 1);
        rd_lit("setclr_pending", IRQ_PENDING, 1);
        wr(IRQ_PENDING, 1);
        rd_lit("w1c_pending", IRQ_PENDING, 0);
        irq_src_i[0] = 1'b0;

        // Illegal claim/complete ids.
        wr(IRQ_ENABLE, 32'hFF);
        irq_src_i = 8'h02;
        idle(4);
        rd_lit("ill_claim_pre", IRQ_CLAIM, 2);
        wr(IRQ_CLAIM, 0);
        wr(IRQ_CLAIM, 9);
        wr(IRQ_CLAIM, 3);
        wr(IRQ_COMPLETE, 2);
        rd_lit("ill_inserv", IRQ_INSERV, 0);
        rd_lit("ill_pending", IRQ_PENDING, 2);
        rd_lit("ill_claim_post", IRQ_CLAIM, 2);
        wr(IRQ_CLAIM, 2);
        wr(IRQ_COMPLETE, 5);
        rd_lit("ill_complete", IRQ_INSERV, 2);
        wr(IRQ_COMPLETE, 2);
        rd_lit("good_complete", IRQ_INSERV, 0);
        rd_lit("undef_off", 8'h18, 0);
        irq_src_i = '0;
        idle(5);

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst = 1'b0;
                rd_lit("mid_rst_pending", IRQ_PENDING, 0);
                rd_lit("mid_rst_enable", IRQ_ENABLE, 0);
                rd_lit("mid_rst_edge", IRQ_EDGE, 0);
                rd_lit("mid_rst_inserv", IRQ_INSERV, 0);
                rd_lit("mid_rst_claim", IRQ_CLAIM, 0);
                irq_lit("mid_rst_irq", 1'b0);
                rst = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, N_SRC - 1);
                irq_src_i[k] = ~irq_src_i[k];
            end
            off = offs[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom;
                if (off == IRQ_CLAIM && $urandom_range(0, 1) == 1) begin
                    c = exp_rd(IRQ_CLAIM);
                    d[4:0] = c[4:0];
                end else if (off == IRQ_COMPLETE && $urandom_range(0, 1) == 1) begin
                    for (int i = N_SRC - 1; i >= 0; i--) if (m_ins[i]) d[4:0] = 5'(i + 1);
                end else if (off == IRQ_CLAIM || off == IRQ_COMPLETE) begin
                    d[4:0] = 5'($urandom_range(0, 10));
                end
                wr(off, d, 24'($urandom));
            end else begin
                we_i = 1'b0;
                addr_i = {24'($urandom), off};
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
